// File: rtl/ram64_dma_pkg.sv
// Shared constants for the ram64 DMA engine and its memory.
// Keeps the address/data widths and state/mode encodings in one place.
package ram64_dma_pkg;
  localparam int RAM_AW = 6;
  localparam int RAM_DW = 16;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RD   = 2'd1,
    ST_WR   = 2'd2,
    ST_DONE = 2'd3
  } state_t;

  localparam logic MODE_COPY = 1'b0;
  localparam logic MODE_FILL = 1'b1;
endpackage

// File: rtl/ram64_dma_if.sv
// Control handshake between a host and the DMA engine: request fields in, status out.
// No backpressure; start is only honoured while the engine is idle.
interface ram64_dma_if
  import ram64_dma_pkg::*;
#(
  parameter int AW = RAM_AW,
  parameter int DW = RAM_DW
);
  logic          start;
  logic          mode;
  logic [AW-1:0] src;
  logic [AW-1:0] dst;
  logic [AW:0]   len;
  logic [DW-1:0] fill;
  logic          busy;
  logic          done;
  logic [AW:0]   words_done;

  modport master (
    output start, mode, src, dst, len, fill,
    input  busy, done, words_done
  );

  modport slave (
    input  start, mode, src, dst, len, fill,
    output busy, done, words_done
  );
endinterface

// File: rtl/ram64.sv
// 2**AW x DW single-port memory: write on rising clk when load, combinational read.
// Zero-latency reads, one-cycle writes; no backpressure.
module ram64
  import ram64_dma_pkg::*;
#(
  parameter int AW = RAM_AW,
  parameter int DW = RAM_DW
) (
  input  logic          clk,
  input  logic [AW-1:0] addr,
  input  logic [DW-1:0] din,
  input  logic          load,
  output logic [DW-1:0] dout
);
  logic [DW-1:0] mem [2**AW];

  always_ff @(posedge clk) begin
    if (load) mem[addr] <= din;
  end

  assign dout = mem[addr];
endmodule

// File: rtl/ram64_dma_addrgen.sv
// Base-address registers, word counter and modulo-2**AW address generation.
// Address is valid in the same cycle as the count; counter steps once per written word.
module ram64_dma_addrgen
  import ram64_dma_pkg::*;
#(
  parameter int AW = RAM_AW
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          load,
  input  logic [AW-1:0] src,
  input  logic [AW-1:0] dst,
  input  logic [AW:0]   len,
  input  logic          step,
  input  logic          sel_dst,
  output logic [AW-1:0] addr,
  output logic [AW:0]   count,
  output logic          last
);
  localparam logic [AW:0] ONE = 1;

  logic [AW-1:0] src_q;
  logic [AW-1:0] dst_q;
  logic [AW:0]   len_q;
  logic [AW:0]   cnt_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      src_q <= '0;
      dst_q <= '0;
      len_q <= '0;
      cnt_q <= '0;
    end else if (load) begin
      src_q <= src;
      dst_q <= dst;
      len_q <= len;
      cnt_q <= '0;
    end else if (step) begin
      cnt_q <= cnt_q + ONE;
    end
  end

  // Truncating to AW bits gives the wrap from 2**AW-1 back to 0.
  assign addr  = (sel_dst ? dst_q : src_q) + cnt_q[AW-1:0];
  assign count = cnt_q;
  assign last  = (cnt_q + ONE) == len_q;
endmodule

// File: rtl/ram64_dma.sv
// Block copy / fill engine driving one ram64; copy costs 2 cycles per word, fill 1.
// start is only sampled in IDLE; no queuing of requests.
module ram64_dma
  import ram64_dma_pkg::*;
#(
  parameter int AW = RAM_AW,
  parameter int DW = RAM_DW
) (
  input  logic          clk,
  input  logic          rst_n,
  ram64_dma_if.slave    ctl,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_in,
  output logic          mem_load,
  input  logic [DW-1:0] mem_out
);
  state_t        state_q, state_d;
  logic          mode_q;
  logic [DW-1:0] fill_q;
  logic [DW-1:0] buf_q;
  logic [DW-1:0] hold_q;
  logic [DW-1:0] wr_data;
  logic [AW-1:0] ag_addr;
  logic          ag_last;
  logic          accept;

  assign accept = (state_q == ST_IDLE) && ctl.start;

  ram64_dma_addrgen #(.AW(AW)) u_addrgen (
    .clk     (clk),
    .rst_n   (rst_n),
    .load    (accept),
    .src     (ctl.src),
    .dst     (ctl.dst),
    .len     (ctl.len),
    .step    (state_q == ST_WR),
    .sel_dst (state_q == ST_WR),
    .addr    (ag_addr),
    .count   (ctl.words_done),
    .last    (ag_last)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      mode_q  <= MODE_COPY;
      fill_q  <= '0;
      buf_q   <= '0;
      hold_q  <= '0;
    end else begin
      state_q <= state_d;
      if (accept) begin
        mode_q <= ctl.mode;
        fill_q <= ctl.fill;
      end
      if (state_q == ST_RD) buf_q  <= mem_out;
      if (state_q == ST_WR) hold_q <= wr_data;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: begin
        if (ctl.start) begin
          if (ctl.len == '0)              state_d = ST_DONE;
          else if (ctl.mode == MODE_FILL) state_d = ST_WR;
          else                            state_d = ST_RD;
        end
      end
      ST_RD:   state_d = ST_WR;
      ST_WR: begin
        if (ag_last)                 state_d = ST_DONE;
        else if (mode_q == MODE_FILL) state_d = ST_WR;
        else                         state_d = ST_RD;
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  assign wr_data  = (mode_q == MODE_FILL) ? fill_q : buf_q;
  // Outside WR the write-data pins keep the last word presented to the RAM.
  assign mem_in   = (state_q == ST_WR) ? wr_data : hold_q;
  assign mem_load = (state_q == ST_WR);
  assign mem_addr = (state_q == ST_RD || state_q == ST_WR) ? ag_addr : '0;

  assign ctl.busy = (state_q == ST_RD) || (state_q == ST_WR);
  assign ctl.done = (state_q == ST_DONE);
endmodule

// File: tb/tb_ram64_dma.sv
// Randomised scoreboard bench: ram64_dma driving a real ram64, checked against an array model.
module tb_ram64_dma;
  import ram64_dma_pkg::*;

  localparam int AW = RAM_AW;
  localparam int DW = RAM_DW;
  localparam int N  = 1 << AW;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  ram64_dma_if #(.AW(AW), .DW(DW)) ifc ();

  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_in;
  logic [DW-1:0] mem_out;
  logic          mem_load;

  ram64_dma #(.AW(AW), .DW(DW)) u_dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .ctl      (ifc),
    .mem_addr (mem_addr),
    .mem_in   (mem_in),
    .mem_load (mem_load),
    .mem_out  (mem_out)
  );

  ram64 #(.AW(AW), .DW(DW)) u_ram (
    .clk  (clk),
    .addr (mem_addr),
    .din  (mem_in),
    .load (mem_load),
    .dout (mem_out)
  );

  int total = 0;
  int bad   = 0;

  logic [DW-1:0] model [N];

  typedef struct packed {
    logic [AW-1:0] a;
    logic [DW-1:0] d;
  } wr_t;

  wr_t exp_q[$];
  wr_t mon_w;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Expected writes: word i goes to dst+i and, for copy, takes whatever the
  // memory holds at src+i at that moment (so overlapping copies propagate).
  task automatic model_op(input logic m, input int s, input int d, input int l,
                          input logic [DW-1:0] f, input int nmax);
    for (int i = 0; i < l && i < nmax; i++) begin
      int a;
      logic [DW-1:0] v;
      a = (d + i) % N;
      v = m ? f : model[(s + i) % N];
      model[a] = v;
      exp_q.push_back({a[AW-1:0], v});
    end
  endtask

  always @(negedge clk) begin
    if (rst_n && mem_load) begin
      if (exp_q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL unexpected_write: got addr=%0d data=%0d expected no write", mem_addr, mem_in);
      end else begin
        mon_w = exp_q.pop_front();
        check("wr_addr", 32'(mem_addr), 32'(mon_w.a));
        check("wr_data", 32'(mem_in), 32'(mon_w.d));
      end
    end
  end

  task automatic set_req(input logic m, input int s, input int d, input int l, input logic [DW-1:0] f);
    ifc.mode = m;
    ifc.src  = s[AW-1:0];
    ifc.dst  = d[AW-1:0];
    ifc.len  = l[AW:0];
    ifc.fill = f;
  endtask

  task automatic run_op(input logic m, input int s, input int d, input int l,
                        input logic [DW-1:0] f, input bit glitch);
    int lat;
    int n;
    bit seen;
    model_op(m, s, d, l, f, l);
    lat = (l == 0) ? 1 : (m ? l + 1 : 2 * l + 1);
    @(posedge clk); #1;
    set_req(m, s, d, l, f);
    ifc.start = 1'b1;
    @(posedge clk); #1;
    ifc.start = 1'b0;
    n = 1;
    seen = 1'b0;
    while (n <= 400) begin
      if (ifc.done) begin
        seen = 1'b1;
        break;
      end
      if (n == 1 && l > 0) check("busy_running", 32'(ifc.busy), 32'd1);
      if (glitch && n == 3) begin
        set_req(~m, (s + 7) % N, (d + 20) % N, 5, ~f);
        ifc.start = 1'b1;
      end else begin
        ifc.start = 1'b0;
      end
      @(posedge clk); #1;
      n++;
    end
    ifc.start = 1'b0;
    check("latency", seen ? n : -1, lat);
    check("words_done", 32'(ifc.words_done), l);
    check("busy_at_done", 32'(ifc.busy), 32'd0);
    if (glitch) begin
      set_req(~m, 3, 3, 6, 16'h1234);
      ifc.start = 1'b1;
      @(posedge clk); #1;
      ifc.start = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      check("start_in_done_ignored", 32'(ifc.busy), 32'd0);
    end
    @(negedge clk);
    check("pending_writes", exp_q.size(), 0);
  endtask

  task automatic check_ram();
    for (int i = 0; i < N; i++)
      check($sformatf("ram[%0d]", i), 32'(u_ram.mem[i]), 32'(model[i]));
  endtask

  initial begin
    ifc.start = 1'b0;
    set_req(1'b0, 0, 0, 0, '0);
    #12;
    check("rst_busy", 32'(ifc.busy), 32'd0);
    check("rst_done", 32'(ifc.done), 32'd0);
    check("rst_load", 32'(mem_load), 32'd0);
    check("rst_addr", 32'(mem_addr), 32'd0);
    check("rst_in", 32'(mem_in), 32'd0);
    check("rst_words", 32'(ifc.words_done), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    run_op(MODE_FILL, 0, 0, 64, 16'h0000, 0);
    run_op(MODE_FILL, 0, 10, 4, 16'h00AB, 0);
    check_ram();

    run_op(MODE_FILL, 0, 0, 1, 16'd123, 0);
    run_op(MODE_FILL, 0, 1, 1, 16'd246, 0);
    run_op(MODE_FILL, 0, 2, 1, 16'd369, 0);
    run_op(MODE_COPY, 0, 40, 3, 16'h0000, 0);

    run_op(MODE_FILL, 0, 62, 4, 16'd7, 0);
    run_op(MODE_COPY, 63, 20, 2, 16'h0000, 0);

    run_op(MODE_FILL, 0, 5, 0, 16'hFFFF, 0);
    run_op(MODE_FILL, 0, 30, 8, 16'h5A5A, 1);

    run_op(MODE_FILL, 0, 5, 1, 16'd99, 0);
    run_op(MODE_COPY, 5, 6, 3, 16'h0000, 0);
    check_ram();

    repeat (20) begin
      run_op(1'($urandom_range(0, 1)), int'($urandom_range(0, N - 1)),
             int'($urandom_range(0, N - 1)), int'($urandom_range(0, N)),
             DW'($urandom), 0);
    end
    check_ram();

    // Reset in the WR cycle of word 2: only words 0 and 1 may land.
    begin
      int n;
      bit found;
      model_op(MODE_COPY, 12, 50, 10, '0, 2);
      @(posedge clk); #1;
      set_req(MODE_COPY, 12, 50, 10, '0);
      ifc.start = 1'b1;
      @(posedge clk); #1;
      ifc.start = 1'b0;
      found = 1'b0;
      for (n = 0; n < 50; n++) begin
        if (ifc.words_done == 7'd2 && mem_load) begin
          found = 1'b1;
          break;
        end
        @(posedge clk); #1;
      end
      check("reach_wr2", 32'(found), 32'd1);
      #2;
      rst_n = 1'b0;
      #1;
      check("midrst_load", 32'(mem_load), 32'd0);
      check("midrst_busy", 32'(ifc.busy), 32'd0);
      check("midrst_addr", 32'(mem_addr), 32'd0);
      @(posedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      repeat (6) @(posedge clk);
      @(negedge clk);
      check("midrst_pending", exp_q.size(), 0);
      check_ram();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
